retire_trace_fifo: RTL and testbench
====================================

# retire_trace_fifo

- Buffers the CPU's per-cycle retire record (`inst_retire`) and presents filtered register-write events to a trace consumer over a valid/ready handshake.
- Sits directly downstream of the custom CPU core and upstream of the simulation trace writer / golden comparator.
- Decouples the consumer from retire bursts, and counts retired writes and dropped records.

## Interface
Parameters:
- `DEPTH`, 16: number of FIFO entries; power of two, 2..256.
- `LW`, `$clog2(DEPTH)+1`: width of `fifo_level` (derived, not overridden).

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_retire`  in  70  retire record, sampled every rising edge:
  - [69] rf_en
  - [68:64] rf_waddr
  - [63:32] rf_wdata
  - [31:0] pc
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  consumer accepts head entry this cycle.
- `trace_pc`  out  32  pc of head entry.
- `trace_waddr`  out  5  destination register of head entry.
- `trace_wdata`  out  32  write data of head entry.
- `fifo_level`  out  LW  number of stored entries, 0..DEPTH.
- `retire_cnt`  out  32  qualifying records accepted into the FIFO; wraps modulo 2^32.
- `drop_cnt`  out  16  qualifying records dropped because the FIFO was full; saturates at 0xFFFF.
- `overflow`  out  1  sticky; set on the first drop, cleared only by reset.

## Operation
- Qualify: a record qualifies when rf_en==1 and rf_waddr!=0. Non-qualifying records are ignored: no push, no counter change.
- Push: a qualifying record is written at `wr_ptr` on the rising edge when the FIFO is not full, or when it is full and a pop occurs on that same edge. The stored entry is {pc, rf_waddr, rf_wdata}; rf_en is not stored.
- Pop: occurs when `trace_valid && trace_ready` at a rising edge; `rd_ptr` advances.
- `trace_ready` while `trace_valid`==0 has no effect.
- Output is first-word-fall-through:
  - `trace_valid` = (`fifo_level` != 0).
  - `trace_pc`/`trace_waddr`/`trace_wdata` are the entry at `rd_ptr` and are stable while `trace_valid`==1 and no pop occurs.
  - When `trace_valid`==0 these outputs are don't-care and are not checked.
- Pointers: `wr_ptr`/`rd_ptr` are `$clog2(DEPTH)` bits and wrap from DEPTH-1 to 0. `fifo_level` is a separate LW-bit counter:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push+pop or neither.
- Full = (`fifo_level` == DEPTH); empty = (`fifo_level` == 0).
- Drop: a qualifying record arriving while full with no pop on that edge is discarded. On that edge `drop_cnt` increments (holds at 0xFFFF) and `overflow` sets.
- `retire_cnt` increments on every accepted push.
- Push and pop on the same edge when empty is not possible. The new entry becomes visible the following cycle; there is no combinational bypass from `inst_retire` to the outputs.
- Order is strictly preserved; no entry is duplicated or skipped.

## Timing
- Reset (asynchronous assert, synchronous-release assumption):
  - `trace_valid`=0, `fifo_level`=0, `retire_cnt`=0, `drop_cnt`=0, `overflow`=0.
  - Pointers are 0.
  - Storage contents are not reset.
- Write latency: a qualifying record sampled at edge N sets `trace_valid`=1 after edge N, with the data on the trace outputs in the same cycle.
- Read: an entry is consumed at the edge where valid&ready. The next entry (if any) is presented immediately after that edge.
- Throughput: one push and one pop per cycle sustained, indefinitely, with no bubbles.
- Counters and `overflow` update on the same edge as the push or drop they record.
- Reset asserted mid-operation immediately clears all state listed above, regardless of clock. Records in flight are lost and not counted.

## Test plan
- Single write: one record {rf_en=1, waddr=5, wdata=0x1234, pc=0xBFC00000} at edge 0, `trace_ready`=0:
  - `trace_valid`=1 after edge 0 with matching fields.
  - `fifo_level`=1, `retire_cnt`=1.
  - Holds until `trace_ready`=1, then `trace_valid`=0 and level=0.
- Filter: records with rf_en=0, and with rf_en=1/waddr=0, for 10 cycles → `trace_valid` stays 0, `retire_cnt`=0, `drop_cnt`=0.
- Overflow: `trace_ready`=0, DEPTH+3 consecutive qualifying records → `fifo_level`=DEPTH, `drop_cnt`=3, `overflow`=1, `retire_cnt`=DEPTH. Draining returns the first DEPTH records in order.
- Full with simultaneous push/pop: FIFO full, `trace_ready`=1, and one qualifying record on the same edge → accepted, `fifo_level` stays DEPTH, `drop_cnt` unchanged.
- Wrap-around: 3*DEPTH+5 qualifying records with pc incrementing by 4, and `trace_ready` toggling pseudo-randomly → consumer sees every pc in order, none missing or duplicated, `retire_cnt` = 3*DEPTH+5.
- Reset mid-operation: assert `rst` between clock edges with level=7 → `trace_valid`, `fifo_level` and all counters go to 0 immediately. After release, a new record is delivered correctly.

Source files
------------

// File: rtl/retire_trace_fifo.sv
// Retire-record trace FIFO: filters register-writing retire records, buffers them
// first-word-fall-through for a valid/ready trace consumer, and counts accepts and drops.
module retire_trace_fifo #(
  parameter int DEPTH = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [69:0]   inst_retire,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_pc,
  output logic [4:0]    trace_waddr,
  output logic [31:0]   trace_wdata,
  output logic [LW-1:0] fifo_level,
  output logic [31:0]   retire_cnt,
  output logic [15:0]   drop_cnt,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  logic          rf_en;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   rec_pc;
  logic          qualify;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [68:0]   head;

  // Entry layout: {pc, waddr, wdata}; rf_en is implied by being stored.
  logic [68:0]   mem [DEPTH];

  assign rf_en    = inst_retire[69];
  assign rf_waddr = inst_retire[68:64];
  assign rf_wdata = inst_retire[63:32];
  assign rec_pc   = inst_retire[31:0];

  assign qualify = rf_en && (rf_waddr != 5'd0);
  assign full    = (fifo_level == LW'(DEPTH));
  assign pop     = trace_valid && trace_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push    = qualify && (!full || pop);
  assign drop    = qualify && full && !pop;

  assign trace_valid = (fifo_level != '0);
  assign head        = mem[rd_ptr];
  assign trace_pc    = head[68:37];
  assign trace_waddr = head[36:32];
  assign trace_wdata = head[31:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rec_pc, rf_waddr, rf_wdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LW'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed bench for retire_trace_fifo: reset, single write, filtering, overflow,
// full push+pop, wrap-around ordering and asynchronous mid-run reset.
module tb_retire_trace_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [69:0]   inst_retire;
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_pc;
  logic [4:0]    trace_waddr;
  logic [31:0]   trace_wdata;
  logic [LW-1:0] fifo_level;
  logic [31:0]   retire_cnt;
  logic [15:0]   drop_cnt;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  retire_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_retire (inst_retire),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_pc    (trace_pc),
    .trace_waddr (trace_waddr),
    .trace_wdata (trace_wdata),
    .fifo_level  (fifo_level),
    .retire_cnt  (retire_cnt),
    .drop_cnt    (drop_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [69:0] mk(input logic en, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic [31:0] pc);
    return {en, wa, wd, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    inst_retire = '0;
    trace_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_retire = '0;
    trace_ready = 1'b0;
    #2;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", trace_valid); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    trace_ready = 1'b0;
    inst_retire = mk(1'b1, 5'd5, 32'h1234, 32'hBFC0_0000);
    tick();
    inst_retire = '0;
    n_checks++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", trace_valid); end
    n_checks++; if (trace_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL single_pc got %h want bfc00000", trace_pc); end
    n_checks++; if (trace_waddr !== 5'd5) begin n_fail++; $display("FAIL single_waddr got %0d want 5", trace_waddr); end
    n_checks++; if (trace_wdata !== 32'h1234) begin n_fail++; $display("FAIL single_wdata got %h want 1234", trace_wdata); end
    n_checks++; if (fifo_level !== LW'(1)) begin n_fail++; $display("FAIL single_level got %0d want 1", fifo_level); end
    n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL single_retire got %0d want 1", retire_cnt); end
    tick();
    tick();
    n_checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL single_hold got valid=%b pc=%h want valid=1 pc=bfc00000", trace_valid, trace_pc);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b want 0", trace_valid); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL single_pop_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_filter();
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) inst_retire = mk(1'b0, 5'(i + 1), 32'(i), 32'h100 + 32'(i));
      else            inst_retire = mk(1'b1, 5'd0, 32'(i), 32'h100 + 32'(i));
      tick();
    end
    inst_retire = '0;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL filter_valid got %b want 0", trace_valid); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL filter_retire got %0d want 0", retire_cnt); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL filter_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      inst_retire = mk(1'b1, 5'((i % 31) + 1), 32'(i * 17), 32'h1000 + 32'(4 * i));
      tick();
    end
    inst_retire = '0;
    n_checks++; if (fifo_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level got %0d want %0d", fifo_level, DEPTH); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_drop got %0d want 3", drop_cnt); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_checks++; if (retire_cnt !== 32'(DEPTH)) begin n_fail++; $display("FAIL ovf_retire got %0d want %0d", retire_cnt, DEPTH); end
  endtask

  // Continues from a full FIFO left by test_overflow, then drains it.
  task automatic test_full_push_pop();
    n_checks++; if (trace_pc !== 32'h1000) begin n_fail++; $display("FAIL fpp_head got %h want 1000", trace_pc); end
    trace_ready = 1'b1;
    inst_retire = mk(1'b1, 5'd7, 32'hAA, 32'h2000);
    tick();
    inst_retire = '0;
    trace_ready = 1'b0;
    n_checks++; if (fifo_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fpp_level got %0d want %0d", fifo_level, DEPTH); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL fpp_drop got %0d want 3", drop_cnt); end
    n_checks++; if (retire_cnt !== 32'(DEPTH + 1)) begin n_fail++; $display("FAIL fpp_retire got %0d want %0d", retire_cnt, DEPTH + 1); end
    trace_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      n_checks++;
      if (trace_valid !== 1'b1 || trace_pc !== 32'h1000 + 32'(4 * i) || trace_wdata !== 32'(i * 17)
          || trace_waddr !== 5'((i % 31) + 1)) begin
        n_fail++;
        $display("FAIL drain_%0d got v=%b pc=%h wd=%h wa=%0d want v=1 pc=%h wd=%h wa=%0d", i, trace_valid,
                 trace_pc, trace_wdata, trace_waddr, 32'h1000 + 32'(4 * i), 32'(i * 17), (i % 31) + 1);
      end
      tick();
    end
    n_checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h2000 || trace_wdata !== 32'hAA) begin
      n_fail++; $display("FAIL drain_last got v=%b pc=%h wd=%h want v=1 pc=2000 wd=aa", trace_valid, trace_pc, trace_wdata);
    end
    tick();
    trace_ready = 1'b0;
    n_checks++; if (trace_valid !== 1'b0 || fifo_level !== '0) begin
      n_fail++; $display("FAIL drain_empty got v=%b level=%0d want v=0 level=0", trace_valid, fifo_level);
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_wrap();
    localparam int N = 3 * DEPTH + 5;
    logic [15:0] rmask;
    int sent;
    int rd_idx;
    int cyc;
    rmask  = 16'b1101_1011_0111_1110;
    sent   = 0;
    rd_idx = 0;
    cyc    = 0;
    apply_reset();
    while (rd_idx < N && cyc < 400) begin
      if (sent < N) begin
        inst_retire = mk(1'b1, 5'd9, 32'(sent), 32'h8000_0000 + 32'(4 * sent));
        trace_ready = rmask[cyc % 16];
        sent++;
      end else begin
        inst_retire = '0;
        trace_ready = 1'b1;
      end
      if (trace_valid && trace_ready) begin
        n_checks++;
        if (trace_pc !== 32'h8000_0000 + 32'(4 * rd_idx)) begin
          n_fail++; $display("FAIL wrap_pc_%0d got %h want %h", rd_idx, trace_pc, 32'h8000_0000 + 32'(4 * rd_idx));
        end
        rd_idx++;
      end
      tick();
      cyc++;
    end
    inst_retire = '0;
    trace_ready = 1'b0;
    n_checks++; if (rd_idx != N) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", rd_idx, N); end
    n_checks++; if (retire_cnt !== 32'(N)) begin n_fail++; $display("FAIL wrap_retire got %0d want %0d", retire_cnt, N); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_drop got %0d want 0", drop_cnt); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b want 0", trace_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      inst_retire = mk(1'b1, 5'd3, 32'(i), 32'h3000 + 32'(4 * i));
      tick();
    end
    inst_retire = '0;
    n_checks++; if (fifo_level !== LW'(7)) begin n_fail++; $display("FAIL mid_level_pre got %0d want 7", fifo_level); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", trace_valid); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    n_checks++; if (retire_cnt !== 32'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_counters got retire=%0d drop=%0d ovf=%b want 0 0 0", retire_cnt, drop_cnt, overflow);
    end
    tick();
    rst = 1'b0;
    inst_retire = mk(1'b1, 5'd31, 32'hDEAD_BEEF, 32'hCAFE_0000);
    tick();
    inst_retire = '0;
    n_checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'hCAFE_0000 || trace_waddr !== 5'd31
                    || trace_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mid_after got v=%b pc=%h wa=%0d wd=%h want v=1 pc=cafe0000 wa=31 wd=deadbeef",
                         trace_valid, trace_pc, trace_waddr, trace_wdata);
    end
    n_checks++; if (fifo_level !== LW'(1) || retire_cnt !== 32'd1) begin
      n_fail++; $display("FAIL mid_after_cnt got level=%0d retire=%0d want 1 1", fifo_level, retire_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
